// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer.
// Holds the ALUCtrl encodings understood by the shared ALU and the
// sequencer state encoding.
package alu_mul_sequencer_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_PASSBM = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASSB  = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Bundle of the multiply request/response signals and the datapath/ALU
// operand buses that the sequencer sits between.
// master: execute stage plus the external ALU result.
// slave:  the sequencer itself.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 64
);
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Product;
    logic             Stall;

    logic [WIDTH-1:0] DpBusA;
    logic [WIDTH-1:0] DpBusB;
    logic [3:0]       DpALUCtrl;

    logic [WIDTH-1:0] AluBusA;
    logic [WIDTH-1:0] AluBusB;
    logic [3:0]       AluCtrl;
    logic [WIDTH-1:0] AluBusW;

    modport master (
        output Start, OpA, OpB,
        output DpBusA, DpBusB, DpALUCtrl,
        output AluBusW,
        input  Busy, Done, Product, Stall,
        input  AluBusA, AluBusB, AluCtrl
    );

    modport slave (
        input  Start, OpA, OpB,
        input  DpBusA, DpBusB, DpALUCtrl,
        input  AluBusW,
        output Busy, Done, Product, Stall,
        output AluBusA, AluBusB, AluCtrl
    );

endinterface

// File: rtl/alu_mul_sequencer_alu_port_mux.sv
// Owner select for the shared ALU operand/control inputs.
// The datapath owns the ALU unless the sequencer is mid-multiply.
module alu_port_mux #(
    parameter int WIDTH = 64
) (
    input  logic             sel_seq,
    input  logic [WIDTH-1:0] dp_bus_a,
    input  logic [WIDTH-1:0] dp_bus_b,
    input  logic [3:0]       dp_ctrl,
    input  logic [WIDTH-1:0] seq_bus_a,
    input  logic [WIDTH-1:0] seq_bus_b,
    input  logic [3:0]       seq_ctrl,
    output logic [WIDTH-1:0] alu_bus_a,
    output logic [WIDTH-1:0] alu_bus_b,
    output logic [3:0]       alu_ctrl
);

    // Combinational passthrough from whichever side currently owns the ALU.
    always_comb begin
        alu_bus_a = dp_bus_a;
        alu_bus_b = dp_bus_b;
        alu_ctrl  = dp_ctrl;
        if (sel_seq) begin
            alu_bus_a = seq_bus_a;
            alu_bus_b = seq_bus_b;
            alu_ctrl  = seq_ctrl;
        end
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Unsigned shift-add multiplier that borrows the shared ALU for each add.
// One multiplier bit is retired per RUN cycle; the low WIDTH bits of the
// product are returned and overflow wraps silently.
//
//   state | meaning
//   IDLE  | datapath owns the ALU, waiting for Start
//   RUN   | sequencer owns the ALU, pipeline stalled, one bit per cycle
//   DONE  | Done pulse for one cycle, Product valid, back to IDLE
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter int         EARLY_EXIT = 1,
    parameter logic [3:0] ADD_CODE   = ALU_ADD
) (
    input logic               Clk,
    input logic               Reset,
    alu_mul_sequencer_if.slave bus
);

    // Wide enough to hold WIDTH-1 with headroom, so it never wraps first.
    localparam int CW = $clog2(WIDTH) + 1;

    seq_state_e       state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [WIDTH-1:0] product, product_n;
    logic [CW-1:0]    count, count_n;

    logic [WIDTH-1:0] acc_upd;
    logic [WIDTH-1:0] mplier_shr;
    logic             last_step;
    logic             busy;

    assign busy        = (state == ST_RUN);
    assign bus.Busy    = busy;
    assign bus.Stall   = busy;
    assign bus.Done    = (state == ST_DONE);
    assign bus.Product = product;

    alu_port_mux #(
        .WIDTH (WIDTH)
    ) u_alu_port_mux (
        .sel_seq   (busy),
        .dp_bus_a  (bus.DpBusA),
        .dp_bus_b  (bus.DpBusB),
        .dp_ctrl   (bus.DpALUCtrl),
        .seq_bus_a (acc),
        .seq_bus_b (mcand),
        .seq_ctrl  (ADD_CODE),
        .alu_bus_a (bus.AluBusA),
        .alu_bus_b (bus.AluBusB),
        .alu_ctrl  (bus.AluCtrl)
    );

    // Per-step datapath terms: conditional add via the ALU and exit test.
    always_comb begin
        acc_upd    = acc;
        mplier_shr = mplier >> 1;
        last_step  = 1'b0;
        if (mplier[0]) begin
            acc_upd = bus.AluBusW;
        end
        if (count == CW'(WIDTH - 1)) begin
            last_step = 1'b1;
        end
        if ((EARLY_EXIT != 0) && (mplier_shr == '0)) begin
            last_step = 1'b1;
        end
    end

    // Next-state and next-register values for the sequencer.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        mcand_n   = mcand;
        mplier_n  = mplier;
        count_n   = count;
        product_n = product;
        case (state)
            ST_IDLE: begin
                if (bus.Start) begin
                    mcand_n  = bus.OpA;
                    mplier_n = bus.OpB;
                    acc_n    = '0;
                    count_n  = '0;
                    if (bus.OpB == '0) begin
                        product_n = '0;
                        state_n   = ST_DONE;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_n    = acc_upd;
                mcand_n  = mcand << 1;
                mplier_n = mplier_shr;
                count_n  = count + CW'(1);
                if (last_step) begin
                    product_n = acc_upd;
                    state_n   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any multiply in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            mcand   <= mcand_n;
            mplier  <= mplier_n;
            count   <= count_n;
            product <= product_n;
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for the shift-add multiply sequencer: one early-exit
// instance and one fixed-latency instance, each with its own ALU model.
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    localparam int W = 64;

    logic Clk = 1'b0;
    logic rst_e;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    alu_mul_sequencer_if #(.WIDTH(W)) bus_e ();
    alu_mul_sequencer_if #(.WIDTH(W)) bus_n ();

    alu_mul_sequencer #(
        .WIDTH      (W),
        .EARLY_EXIT (1),
        .ADD_CODE   (ALU_ADD)
    ) dut_e (
        .Clk   (Clk),
        .Reset (rst_e),
        .bus   (bus_e.slave)
    );

    alu_mul_sequencer #(
        .WIDTH      (W),
        .EARLY_EXIT (0),
        .ADD_CODE   (ALU_ADD)
    ) dut_n (
        .Clk   (Clk),
        .Reset (rst_n),
        .bus   (bus_n.slave)
    );

    function automatic logic [W-1:0] alu_model(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic [3:0]   c);
        case (c)
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_PASSB:  return b;
            ALU_PASSBM: return ~b;
            default:    return '0;
        endcase
    endfunction

    assign bus_e.AluBusW = alu_model(bus_e.AluBusA, bus_e.AluBusB, bus_e.AluCtrl);
    assign bus_n.AluBusW = alu_model(bus_n.AluBusA, bus_n.AluBusB, bus_n.AluCtrl);

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic obs_done(input bit sel);
        return sel ? bus_n.Done : bus_e.Done;
    endfunction

    function automatic logic obs_busy(input bit sel);
        return sel ? bus_n.Busy : bus_e.Busy;
    endfunction

    function automatic logic [W-1:0] obs_prod(input bit sel);
        return sel ? bus_n.Product : bus_e.Product;
    endfunction

    // Issue one multiply, then check Done latency, result and RUN length.
    task automatic run_mul(input bit sel, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int exp_lat, input logic [W-1:0] exp_prod, input string tag);
        int n;
        int busy_n;
        if (sel) begin
            bus_n.OpA = a; bus_n.OpB = b; bus_n.Start = 1'b1;
        end else begin
            bus_e.OpA = a; bus_e.OpB = b; bus_e.Start = 1'b1;
        end
        tick();
        bus_e.Start = 1'b0;
        bus_n.Start = 1'b0;
        n = 1;
        busy_n = 0;
        while (obs_done(sel) !== 1'b1 && n < 300) begin
            if (obs_busy(sel) === 1'b1) busy_n++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
        chk({tag, "_product"}, obs_prod(sel), exp_prod);
        chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        tick();
        chk({tag, "_done_drop"}, {63'd0, obs_done(sel)}, 64'd0);
    endtask

    logic [W-1:0] exp_a [3];
    logic [W-1:0] exp_b [3];

    initial begin
        int  n;
        bit  done_seen;

        bus_e.Start = 1'b0; bus_e.OpA = '0; bus_e.OpB = '0;
        bus_e.DpBusA = '0; bus_e.DpBusB = '0; bus_e.DpALUCtrl = 4'b0000;
        bus_n.Start = 1'b0; bus_n.OpA = '0; bus_n.OpB = '0;
        bus_n.DpBusA = '0; bus_n.DpBusB = '0; bus_n.DpALUCtrl = 4'b0000;
        rst_e = 1'b1;
        rst_n = 1'b1;
        tick();
        tick();
        rst_e = 1'b0;
        rst_n = 1'b0;

        // Reset state
        chk("rst_busy",    {63'd0, bus_e.Busy},  64'd0);
        chk("rst_done",    {63'd0, bus_e.Done},  64'd0);
        chk("rst_stall",   {63'd0, bus_e.Stall}, 64'd0);
        chk("rst_product", bus_e.Product,        64'd0);

        // Idle passthrough
        bus_e.DpBusA = 64'd7; bus_e.DpBusB = 64'd9; bus_e.DpALUCtrl = 4'b0110;
        #1;
        chk("pass_a",    bus_e.AluBusA,        64'd7);
        chk("pass_b",    bus_e.AluBusB,        64'd9);
        chk("pass_ctrl", {60'd0, bus_e.AluCtrl}, 64'd6);

        // 3 * 5, per-cycle ALU ownership while the datapath bus changes
        exp_a[0] = 64'd0; exp_a[1] = 64'd3; exp_a[2] = 64'd3;
        exp_b[0] = 64'd3; exp_b[1] = 64'd6; exp_b[2] = 64'd12;
        bus_e.OpA = 64'd3; bus_e.OpB = 64'd5; bus_e.Start = 1'b1;
        tick();
        bus_e.Start = 1'b0;
        bus_e.DpBusA = 64'hDEAD; bus_e.DpBusB = 64'hBEEF; bus_e.DpALUCtrl = 4'b0111;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("m35_busy",  {63'd0, bus_e.Busy},  64'd1);
            chk("m35_stall", {63'd0, bus_e.Stall}, 64'd1);
            chk("m35_ctrl",  {60'd0, bus_e.AluCtrl}, 64'd2);
            chk("m35_alu_a", bus_e.AluBusA, exp_a[i]);
            chk("m35_alu_b", bus_e.AluBusB, exp_b[i]);
            tick();
        end
        chk("m35_done",    {63'd0, bus_e.Done}, 64'd1);
        chk("m35_idle",    {63'd0, bus_e.Busy}, 64'd0);
        chk("m35_product", bus_e.Product, 64'd15);
        chk("m35_done_passthru", bus_e.AluBusA, 64'hDEAD);
        // Start during DONE must be ignored
        bus_e.OpA = 64'd1; bus_e.OpB = 64'd1; bus_e.Start = 1'b1;
        tick();
        bus_e.Start = 1'b0;
        chk("done_start_done", {63'd0, bus_e.Done}, 64'd0);
        chk("done_start_busy", {63'd0, bus_e.Busy}, 64'd0);
        tick();
        chk("done_start_busy2", {63'd0, bus_e.Busy}, 64'd0);
        chk("done_start_prod",  bus_e.Product, 64'd15);

        // Wrap cases and zero multiplier
        run_mul(1'b0, 64'h8000_0000_0000_0000, 64'd2, 3, 64'd0, "wrap_msb");
        run_mul(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65, 64'd1, "ones");
        run_mul(1'b0, 64'd123, 64'd0, 1, 64'd0, "zero_b");

        // Start pulsed mid-RUN with other operands is ignored
        bus_e.OpA = 64'd7; bus_e.OpB = 64'h1000; bus_e.Start = 1'b1;
        tick();
        bus_e.Start = 1'b0;
        tick();
        tick();
        bus_e.OpA = 64'd5; bus_e.OpB = 64'd3; bus_e.Start = 1'b1;
        tick();
        bus_e.Start = 1'b0;
        n = 4;
        while (bus_e.Done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk("midstart_latency", 64'(n), 64'd14);
        chk("midstart_product", bus_e.Product, 64'h7000);
        tick();

        // Reset mid-RUN aborts with no Done
        bus_e.OpA = 64'd9; bus_e.OpB = 64'h100; bus_e.Start = 1'b1;
        tick();
        bus_e.Start = 1'b0;
        tick();
        tick();
        tick();
        rst_e = 1'b1;
        tick();
        rst_e = 1'b0;
        chk("abort_busy",    {63'd0, bus_e.Busy},  64'd0);
        chk("abort_stall",   {63'd0, bus_e.Stall}, 64'd0);
        chk("abort_done",    {63'd0, bus_e.Done},  64'd0);
        chk("abort_product", bus_e.Product, 64'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus_e.Done === 1'b1) done_seen = 1'b1;
        end
        chk("abort_no_done", {63'd0, done_seen}, 64'd0);

        // Fixed-latency build
        run_mul(1'b1, 64'd3, 64'd1, 65, 64'd3, "noexit_3x1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
